// File: rtl/clock_set_controller.sv
// Keypad time/alarm entry controller for a digital clock.
// Collects BCD HH:MM digits, validates on commit and steers the display source.
module clock_set_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        key_valid,
  input  logic [3:0]  key,
  input  logic        load_time_btn,
  input  logic        load_alarm_btn,
  input  logic        show_alarm_btn,
  output logic [15:0] set_data,
  output logic        load_time,
  output logic        load_alarm,
  output logic        show_time,
  output logic        show_new_time,
  output logic        show_alarm,
  output logic        entry_error
);

  typedef enum logic [1:0] {StShowTime, StKeyEntry, StShowAlarm} state_e;

  localparam logic [3:0] TimeoutTicks = 4'd10;

  state_e      state_q, state_d;
  logic [15:0] set_data_q, set_data_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [3:0]  timeout_q, timeout_d;
  logic        load_time_q, load_time_d;
  logic        load_alarm_q, load_alarm_d;
  logic        entry_error_q, entry_error_d;
  logic        show_time_q, show_time_d;
  logic        show_new_time_q, show_new_time_d;
  logic        show_alarm_q, show_alarm_d;

  logic is_digit;
  logic commit_busy;
  logic entry_ok;

  assign is_digit    = key_valid && (key <= 4'd9);
  // A commit pulse is in flight; KEY_ENTRY waits one cycle before returning.
  assign commit_busy = load_time_q || load_alarm_q || entry_error_q;

  always_comb begin
    entry_ok = (digit_cnt_q == 3'd4)
             && (set_data_q[15:12] <= 4'd2)
             && (set_data_q[11:8] <= 4'd9)
             && ((set_data_q[15:12] != 4'd2) || (set_data_q[11:8] <= 4'd3))
             && (set_data_q[7:4] <= 4'd5)
             && (set_data_q[3:0] <= 4'd9);
  end

  always_comb begin
    state_d       = state_q;
    set_data_d    = set_data_q;
    digit_cnt_d   = digit_cnt_q;
    timeout_d     = timeout_q;
    load_time_d   = 1'b0;
    load_alarm_d  = 1'b0;
    entry_error_d = 1'b0;

    unique case (state_q)
      StShowTime: begin
        timeout_d = 4'd0;
        if (is_digit) begin
          set_data_d  = {12'h000, key};
          digit_cnt_d = 3'd1;
          state_d     = StKeyEntry;
        end else if (show_alarm_btn) begin
          state_d = StShowAlarm;
        end
      end
      StKeyEntry: begin
        if (commit_busy) begin
          state_d   = StShowTime;
          timeout_d = 4'd0;
        end else if (load_time_btn || load_alarm_btn) begin
          // Time wins when both buttons are pressed together.
          if (entry_ok) begin
            load_time_d  = load_time_btn;
            load_alarm_d = !load_time_btn;
          end else begin
            entry_error_d = 1'b1;
          end
          timeout_d = 4'd0;
        end else if (is_digit) begin
          set_data_d  = {set_data_q[11:0], key};
          digit_cnt_d = (digit_cnt_q == 3'd4) ? 3'd4 : digit_cnt_q + 3'd1;
          timeout_d   = 4'd0;
        end else if (one_second) begin
          if (timeout_q == TimeoutTicks - 4'd1) begin
            timeout_d = 4'd0;
            state_d   = StShowTime;
          end else begin
            timeout_d = timeout_q + 4'd1;
          end
        end
      end
      StShowAlarm: begin
        if (!show_alarm_btn) begin
          state_d = StShowTime;
        end
      end
      default: begin
        state_d = StShowTime;
      end
    endcase

    show_time_d     = (state_d == StShowTime);
    show_new_time_d = (state_d == StKeyEntry);
    show_alarm_d    = (state_d == StShowAlarm);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StShowTime;
      set_data_q      <= 16'h0000;
      digit_cnt_q     <= 3'd0;
      timeout_q       <= 4'd0;
      load_time_q     <= 1'b0;
      load_alarm_q    <= 1'b0;
      entry_error_q   <= 1'b0;
      show_time_q     <= 1'b1;
      show_new_time_q <= 1'b0;
      show_alarm_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      set_data_q      <= set_data_d;
      digit_cnt_q     <= digit_cnt_d;
      timeout_q       <= timeout_d;
      load_time_q     <= load_time_d;
      load_alarm_q    <= load_alarm_d;
      entry_error_q   <= entry_error_d;
      show_time_q     <= show_time_d;
      show_new_time_q <= show_new_time_d;
      show_alarm_q    <= show_alarm_d;
    end
  end

  assign set_data      = set_data_q;
  assign load_time     = load_time_q;
  assign load_alarm    = load_alarm_q;
  assign show_time     = show_time_q;
  assign show_new_time = show_new_time_q;
  assign show_alarm    = show_alarm_q;
  assign entry_error   = entry_error_q;

endmodule
